tff_counter_ctrl: RTL

Sequencing controller for an external bank of `WIDTH` T flip-flops, each with ports T, clk, reset and Q. The controller reads the bank's Q outputs and drives one toggle enable per bit, so the bank behaves as a programmable up/down counter. The counter supports start/stop, synchronous clear, parallel load, a terminal-count limit and an optional wrap. The bank shares `clk` and `reset` with this block.

---
 rtl/tff_counter_ctrl_if.sv | 34 +++
 rtl/tff_counter_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/tff_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tff_counter_ctrl_if
// Description : Command, status and T-flip-flop bank signals for tff_counter_ctrl
// Revision    : 1.0  initial release
// ============================================================================
interface tff_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic             wrap;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_en;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output start, stop, clear, load, load_val, dir, limit, wrap, q,
        input  t_en, busy, done, tc
    );

    modport slave (
        input  start, stop, clear, load, load_val, dir, limit, wrap, q,
        output t_en, busy, done, tc
    );
endinterface
`default_nettype wire

// File: rtl/tff_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tff_counter_ctrl
// Description : Drives toggle enables of an external T flip-flop bank so it
//               behaves as an up/down counter with load, clear and limit.
// Revision    : 1.0  initial release
// ============================================================================
module tff_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    tff_counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] up_en;
    logic [WIDTH-1:0] dn_en;
    logic [WIDTH-1:0] t_en_c;
    logic             tc_c;
    logic             at_term;

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        up_en    = '0;
        dn_en    = '0;
        up_en[0] = 1'b1;
        dn_en[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_en[i] = up_en[i-1] &  bus.q[i-1];
            dn_en[i] = dn_en[i-1] & ~bus.q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        t_en_c     = '0;
        tc_c       = 1'b0;
        at_term    = bus.dir ? (bus.q == bus.limit) : (bus.q == '0);
        if (reset) begin
            next_state = IDLE;
        end else if (bus.clear) begin
            t_en_c     = bus.q;
            next_state = IDLE;
        end else if (bus.load) begin
            t_en_c     = bus.q ^ bus.load_val;
            next_state = IDLE;
        end else if (bus.stop) begin
            if (state == RUN) begin
                next_state = IDLE;
            end
        end else if (bus.start && (state != RUN)) begin
            next_state = RUN;
        end else if (state == RUN) begin
            if (at_term) begin
                tc_c = 1'b1;
                if (bus.wrap) begin
                    t_en_c = bus.dir ? bus.q : bus.limit;
                end else begin
                    next_state = DONE;
                end
            end else begin
                t_en_c = bus.dir ? up_en : dn_en;
            end
        end
    end

    assign bus.t_en = t_en_c;
    assign bus.tc   = tc_c;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule
`default_nettype wire
